// File: rtl/mc_controller.sv
// mc_controller: multicycle RV32I control FSM with a req/ready memory handshake.
// Define CTRL_ILLEGAL_TRAP_EN to trap unknown opcodes and raise a sticky illegal flag.
module mc_controller #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic       illegal
);
    // RESET_STATE must match the FETCH encoding below
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
        ALUWB, BRANCH, JAL, JALR, JALR2, LUI, AUIPC, TRAP
    } state_t;
    localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011,
                           OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                           ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7,
                           ALU_SRL = 4'd8, ALU_SRA = 4'd9;
    localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011,
                           IMM_U = 3'b100;
    state_t state_q, state_d, bad_next;
    logic   taken;
    function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_dec = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_dec = ALU_SLL;
            3'b010:  alu_dec = ALU_SLT;
            3'b011:  alu_dec = ALU_SLTU;
            3'b100:  alu_dec = ALU_XOR;
            3'b101:  alu_dec = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_dec = ALU_OR;
            default: alu_dec = ALU_AND;
        endcase
    endfunction
    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = lt;
            3'b101:  taken = !lt;
            3'b110:  taken = ltu;
            3'b111:  taken = !ltu;
            default: taken = 1'b0;
        endcase
    end
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;
    assign bad_next = TRAP;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) illegal_q <= 1'b0;
        else if (state_d == TRAP) illegal_q <= 1'b1;
    end
    assign illegal = illegal_q;
`else
    assign bad_next = FETCH;
    assign illegal  = 1'b0;
`endif
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= state_t'(RESET_STATE);
        else state_q <= state_d;
    end
    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        ImmSrc     = IMM_I;
        case (state_q)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    IRWrite   = 1'b1;
                    PCWrite   = 1'b1;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    state_d   = DECODE;
                end
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
                case (op)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_R:              state_d = EXECR;
                    OP_I:              state_d = EXECI;
                    OP_BR:             state_d = BRANCH;
                    OP_JAL:            state_d = JAL;
                    OP_JALR:           state_d = JALR;
                    OP_LUI:            state_d = LUI;
                    OP_AUIPC:          state_d = AUIPC;
                    default:           state_d = bad_next;
                endcase
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = (op == OP_STORE) ? IMM_S : IMM_I;
                state_d = (op == OP_STORE) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                state_d = mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                state_d   = FETCH;
            end
            MEMWRITE: begin
                mem_req  = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
                state_d  = mem_ready ? FETCH : MEMWRITE;
            end
            EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_dec(funct3, funct7b5);
                state_d    = ALUWB;
            end
            EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_dec(funct3, funct7b5 && funct3 == 3'b101);
                state_d    = ALUWB;
            end
            ALUWB: begin
                RegWrite = 1'b1;
                state_d  = FETCH;
            end
            BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                PCWrite    = taken;
                state_d    = FETCH;
            end
            JAL, JALR2: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                state_d = ALUWB;
            end
            JALR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = JALR2;
            end
            LUI: begin
                ImmSrc    = IMM_U;
                ResultSrc = 2'b11;
                RegWrite  = 1'b1;
                state_d   = FETCH;
            end
            AUIPC: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = IMM_U;
                state_d = ALUWB;
            end
            default: state_d = state_q;
        endcase
        if (!reset_n) begin
            mem_req  = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            RegWrite = 1'b0;
        end
    end
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed-vector bench for the multicycle control FSM.
module tb_mc_controller;
    logic       clk = 1'b0;
    logic       reset_n, funct7b5, zero, lt, ltu, mem_ready;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [3:0] ALUControl;
    logic [2:0] ImmSrc;
    int n_chk = 0;
    int n_fail = 0;

    mc_controller dut (
        .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready), .mem_req(mem_req),
        .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .ImmSrc(ImmSrc), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op = o;
        funct3 = f3;
        funct7b5 = f7;
    endtask

    // completes a fetch from FETCH (mem_ready high) and lands in DECODE
    task automatic fetch(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        set_instr(o, f3, f7);
        mem_ready = 1'b1;
        #1;
        chk("fetch_irwrite", IRWrite, 1'b1);
        tick();
    endtask

    initial begin
        reset_n = 1'b1;
        mem_ready = 1'b1;
        zero = 1'b0;
        lt = 1'b0;
        ltu = 1'b0;
        set_instr(7'b0000011, 3'b010, 1'b0);
        #1 reset_n = 1'b0;
        #2;
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_pcwrite", PCWrite, 1'b0);
        chk("rst_illegal", illegal, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        chk("rst_held_mem_req", mem_req, 1'b0);
        chk("rst_held_irwrite", IRWrite, 1'b0);
        mem_ready = 1'b0;
        reset_n = 1'b1;
        tick();
        chk("fetch_wait_mem_req", mem_req, 1'b1);
        chk("fetch_wait_irwrite", IRWrite, 1'b0);
        chk("fetch_adrsrc", AdrSrc, 1'b0);
        tick();
        chk("fetch_wait2_irwrite", IRWrite, 1'b0);
        tick();
        mem_ready = 1'b1;
        #1;
        chk("fetch_done_irwrite", IRWrite, 1'b1);
        chk("fetch_done_pcwrite", PCWrite, 1'b1);
        chk("fetch_alusrcb", ALUSrcB, 2'b10);
        chk("fetch_resultsrc", ResultSrc, 2'b10);
        tick();
        chk("lw_decode_irwrite", IRWrite, 1'b0);
        chk("lw_decode_pcwrite", PCWrite, 1'b0);
        chk("lw_decode_mem_req", mem_req, 1'b0);
        chk("lw_decode_immsrc", ImmSrc, 3'b010);
        chk("lw_decode_alusrca", ALUSrcA, 2'b01);
        tick();
        chk("lw_memadr_immsrc", ImmSrc, 3'b000);
        chk("lw_memadr_alusrca", ALUSrcA, 2'b10);
        chk("lw_memadr_alusrcb", ALUSrcB, 2'b01);
        tick();
        chk("lw_memread_mem_req", mem_req, 1'b1);
        chk("lw_memread_adrsrc", AdrSrc, 1'b1);
        chk("lw_memread_memwrite", MemWrite, 1'b0);
        tick();
        chk("lw_memwb_regwrite", RegWrite, 1'b1);
        chk("lw_memwb_resultsrc", ResultSrc, 2'b01);
        tick();
        chk("lw_back_fetch", mem_req, 1'b1);
        fetch(7'b0100011, 3'b010, 1'b0);
        tick();
        chk("sw_memadr_immsrc", ImmSrc, 3'b001);
        mem_ready = 1'b0;
        tick();
        chk("sw_w1_memwrite", MemWrite, 1'b1);
        chk("sw_w1_adrsrc", AdrSrc, 1'b1);
        chk("sw_w1_regwrite", RegWrite, 1'b0);
        tick();
        chk("sw_w2_memwrite", MemWrite, 1'b1);
        tick();
        mem_ready = 1'b1;
        #1;
        chk("sw_w3_memwrite", MemWrite, 1'b1);
        tick();
        chk("sw_done_memwrite", MemWrite, 1'b0);
        chk("sw_done_fetch", mem_req, 1'b1);
        fetch(7'b1100011, 3'b001, 1'b0);
        chk("bne_decode_immsrc", ImmSrc, 3'b010);
        tick();
        zero = 1'b0;
        #1;
        chk("bne_taken", PCWrite, 1'b1);
        chk("branch_aluctl", ALUControl, 4'd1);
        zero = 1'b1;
        #1;
        chk("bne_not_taken", PCWrite, 1'b0);
        funct3 = 3'b110;
        ltu = 1'b1;
        #1;
        chk("bltu_taken", PCWrite, 1'b1);
        ltu = 1'b0;
        #1;
        chk("bltu_not_taken", PCWrite, 1'b0);
        funct3 = 3'b010;
        zero = 1'b1;
        #1;
        chk("b010_never", PCWrite, 1'b0);
        tick();
        fetch(7'b0110011, 3'b000, 1'b1);
        tick();
        chk("sub_aluctl", ALUControl, 4'd1);
        chk("sub_alusrcb", ALUSrcB, 2'b00);
        funct3 = 3'b101;
        #1;
        chk("sra_r_aluctl", ALUControl, 4'd9);
        tick();
        chk("alu_wb_regwrite", RegWrite, 1'b1);
        chk("alu_wb_resultsrc", ResultSrc, 2'b00);
        tick();
        fetch(7'b0010011, 3'b000, 1'b1);
        tick();
        chk("addi_b30_aluctl", ALUControl, 4'd0);
        chk("addi_immsrc", ImmSrc, 3'b000);
        funct3 = 3'b101;
        #1;
        chk("srai_aluctl", ALUControl, 4'd9);
        funct7b5 = 1'b0;
        #1;
        chk("srli_aluctl", ALUControl, 4'd8);
        tick();
        tick();
        fetch(7'b1101111, 3'b000, 1'b0);
        chk("jal_decode_immsrc", ImmSrc, 3'b011);
        tick();
        chk("jal_pcwrite", PCWrite, 1'b1);
        chk("jal_regwrite", RegWrite, 1'b0);
        chk("jal_alusrca", ALUSrcA, 2'b01);
        tick();
        chk("jal_wb_regwrite", RegWrite, 1'b1);
        chk("jal_wb_pcwrite", PCWrite, 1'b0);
        tick();
        fetch(7'b0110111, 3'b000, 1'b0);
        tick();
        chk("lui_resultsrc", ResultSrc, 2'b11);
        chk("lui_immsrc", ImmSrc, 3'b100);
        chk("lui_regwrite", RegWrite, 1'b1);
        tick();
        fetch(7'b0000000, 3'b000, 1'b0);
        tick();
`ifdef CTRL_ILLEGAL_TRAP_EN
        chk("trap_illegal", illegal, 1'b1);
        chk("trap_mem_req", mem_req, 1'b0);
        repeat (3) tick();
        chk("trap_stays_mem_req", mem_req, 1'b0);
        chk("trap_stays_illegal", illegal, 1'b1);
`else
        chk("nop_illegal", illegal, 1'b0);
        chk("nop_back_fetch", mem_req, 1'b1);
`endif
        mem_ready = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_mem_req", mem_req, 1'b0);
        chk("midrst_illegal", illegal, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        chk("post_rst_mem_req", mem_req, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
